// File: rtl/seg_scan_controller.sv
// Time-multiplexed scan controller for a multi-digit 7-segment display.
// Holds a double-buffered BCD frame and steps a shared decoder through it digit by digit.
module seg_scan_controller #(
    parameter int NUM_DIGITS   = 4,
    parameter int SLOT_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    wr_valid,
    input  logic [4*NUM_DIGITS-1:0] wr_data,
    output logic                    wr_ready,
    output logic [3:0]              bcd_out,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    blank,
    output logic [2:0]              cur_digit,
    output logic                    frame_done,
    output logic [1:0]              dbg_state
);

    localparam int CW = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [2:0]    LAST_DIGIT = 3'(NUM_DIGITS - 1);
    localparam logic [4*NUM_DIGITS-1:0] ALL_BLANK = {NUM_DIGITS{4'hF}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_SHOW  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [2:0]              cur_digit_q, cur_digit_d;
    logic [4*NUM_DIGITS-1:0] display_q, display_d;
    logic [4*NUM_DIGITS-1:0] pend_data_q, pend_data_d;
    logic                    pending_q, pending_d;
    logic                    wr_ready_q, wr_ready_d;
    logic [3:0]              bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0]   dig_en_q, dig_en_d;
    logic                    blank_q, blank_d;
    logic                    frame_done_q, frame_done_d;
    logic                    commit;
    logic                    accept;
    logic [3:0]              digit_d;

    // Write port: a word transfers on any cycle where wr_valid && wr_ready are both high.
    // wr_ready is the registered inverse of the pending flag, so a transfer and a
    // commit of the pending buffer can never happen in the same cycle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cur_digit_d  = cur_digit_q;
        display_d    = display_q;
        pend_data_d  = pend_data_q;
        pending_d    = pending_q;
        frame_done_d = 1'b0;
        commit       = 1'b0;
        accept       = wr_valid && wr_ready_q;

        case (state_q)
            S_IDLE: begin
                commit = pending_q;
                if (en) begin
                    state_d     = S_BLANK;
                    cnt_d       = '0;
                    cur_digit_d = '0;
                end
            end
            S_BLANK: begin
                if (!en) begin
                    state_d     = S_IDLE;
                    cnt_d       = '0;
                    cur_digit_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == BLANK_LAST) begin
                        state_d = S_SHOW;
                    end
                end
            end
            S_SHOW: begin
                if (!en) begin
                    state_d     = S_IDLE;
                    cnt_d       = '0;
                    cur_digit_d = '0;
                end else if (cnt_q == SLOT_LAST) begin
                    state_d = S_BLANK;
                    cnt_d   = '0;
                    if (cur_digit_q == LAST_DIGIT) begin
                        cur_digit_d  = '0;
                        frame_done_d = 1'b1;
                        commit       = pending_q;
                    end else begin
                        cur_digit_d = cur_digit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                cnt_d       = '0;
                cur_digit_d = '0;
            end
        endcase

        if (commit) begin
            display_d = pend_data_q;
            pending_d = 1'b0;
        end
        if (accept) begin
            pend_data_d = wr_data;
            pending_d   = 1'b1;
        end

        // Outputs are derived from the next-state values so they line up with the registered state.
        digit_d    = display_d[4*cur_digit_d +: 4];
        wr_ready_d = !pending_d;
        bcd_d      = (state_d == S_IDLE) ? 4'd0 : digit_d;
        dig_en_d   = '0;
        blank_d    = 1'b1;
        if (state_d == S_SHOW && digit_d <= 4'd9) begin
            dig_en_d = NUM_DIGITS'(1) << cur_digit_d;
            blank_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            cur_digit_q  <= '0;
            display_q    <= ALL_BLANK;
            pend_data_q  <= '0;
            pending_q    <= 1'b0;
            wr_ready_q   <= 1'b1;
            bcd_q        <= 4'd0;
            dig_en_q     <= '0;
            blank_q      <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cur_digit_q  <= cur_digit_d;
            display_q    <= display_d;
            pend_data_q  <= pend_data_d;
            pending_q    <= pending_d;
            wr_ready_q   <= wr_ready_d;
            bcd_q        <= bcd_d;
            dig_en_q     <= dig_en_d;
            blank_q      <= blank_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign wr_ready   = wr_ready_q;
    assign bcd_out    = bcd_q;
    assign dig_en     = dig_en_q;
    assign blank      = blank_q;
    assign cur_digit  = cur_digit_q;
    assign frame_done = frame_done_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed bench for seg_scan_controller: a time-based display model checked every cycle,
// plus hand-computed spot checks along a scripted scenario.
module tb_seg_scan_controller;

  localparam int N = 4;
  localparam int S = 8;
  localparam int B = 2;
  localparam int FRAME = N * S;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic wr_valid;
  logic [4*N-1:0] wr_data;
  logic wr_ready;
  logic [3:0] bcd_out;
  logic [N-1:0] dig_en;
  logic blank;
  logic [2:0] cur_digit;
  logic frame_done;
  logic [1:0] dbg_state;

  int total = 0;
  int bad = 0;
  bit chk_on = 0;

  seg_scan_controller #(
    .NUM_DIGITS(N),
    .SLOT_CYCLES(S),
    .BLANK_CYCLES(B)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .wr_valid(wr_valid),
    .wr_data(wr_data),
    .wr_ready(wr_ready),
    .bcd_out(bcd_out),
    .dig_en(dig_en),
    .blank(blank),
    .cur_digit(cur_digit),
    .frame_done(frame_done),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Scan position is derived purely from elapsed cycles since the scan started.
  bit         m_run;
  int         m_t;
  logic [3:0] m_disp[N];
  bit         m_pend;
  logic [4*N-1:0] m_pdata;
  bit         m_fd;

  task automatic model_commit();
    for (int k = 0; k < N; k++) m_disp[k] = m_pdata[4*k +: 4];
    m_pend = 0;
  endtask

  always @(posedge clk) begin
    bit acc;
    if (!rst_n) begin
      m_run = 0;
      m_t = 0;
      for (int k = 0; k < N; k++) m_disp[k] = 4'hF;
      m_pend = 0;
      m_pdata = '0;
      m_fd = 0;
    end else begin
      acc = wr_valid && !m_pend;
      m_fd = 0;
      if (!m_run) begin
        if (m_pend) model_commit();
        if (en) begin
          m_run = 1;
          m_t = 0;
        end
      end else if (!en) begin
        m_run = 0;
      end else begin
        m_t++;
        if (m_t % FRAME == 0) begin
          m_fd = 1;
          if (m_pend) model_commit();
        end
      end
      if (acc) begin
        m_pend = 1;
        m_pdata = wr_data;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int d, ph;
    logic [3:0] code;
    logic [N-1:0] e_en;
    logic e_blank;
    logic [3:0] e_bcd;
    logic [2:0] e_cur;
    if (chk_on) begin
      if (!m_run) begin
        e_en = '0;
        e_blank = 1'b1;
        e_bcd = 4'd0;
        e_cur = 3'd0;
      end else begin
        d = (m_t / S) % N;
        ph = m_t % S;
        code = m_disp[d];
        e_bcd = code;
        e_cur = 3'(d);
        if (ph >= B && code <= 4'd9) begin
          e_en = N'(1) << d;
          e_blank = 1'b0;
        end else begin
          e_en = '0;
          e_blank = 1'b1;
        end
      end
      check("m_dig_en", 32'(dig_en), 32'(e_en));
      check("m_blank", 32'(blank), 32'(e_blank));
      check("m_bcd_out", 32'(bcd_out), 32'(e_bcd));
      check("m_cur_digit", 32'(cur_digit), 32'(e_cur));
      check("m_frame_done", 32'(frame_done), 32'(m_fd));
      check("m_wr_ready", 32'(wr_ready), 32'(!m_pend));
      check("onehot0_dig_en", 32'($onehot0(dig_en)), 32'd1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents a word and holds it until the handshake completes; caller drops wr_valid.
  task automatic write(input logic [4*N-1:0] data);
    int i;
    wr_valid = 1'b1;
    wr_data = data;
    i = 0;
    while (!wr_ready && i < 200) begin
      tick(1);
      i++;
    end
    if (i >= 200) check("write_timeout", 32'd0, 32'd1);
    tick(1);
  endtask

  task automatic wait_fd(output int n);
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!frame_done && n < 200);
    if (n >= 200) check("frame_done_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- directed scenario ----------------
  initial begin
    int n;
    rst_n = 1'b0;
    en = 1'b0;
    wr_valid = 1'b0;
    wr_data = '0;

    // 1. reset and first frame of all-blank digits
    tick(1);
    chk_on = 1;
    tick(2);
    check("rst_dig_en", 32'(dig_en), 32'd0);
    check("rst_blank", 32'(blank), 32'd1);
    check("rst_bcd_out", 32'(bcd_out), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    rst_n = 1'b1;
    en = 1'b1;
    wait_fd(n);
    check("first_fd_latency", 32'(n), 32'd33);
    check("blank_frame_bcd", 32'(bcd_out), 32'hF);
    tick(10);

    // 2. write mid-frame, commit at boundary
    write(16'h4321);
    wr_valid = 1'b0;
    check("wr_ready_after_accept", 32'(wr_ready), 32'd0);
    wait_fd(n);
    check("fd_after_write", 32'(n), 32'd21);
    check("commit_wr_ready", 32'(wr_ready), 32'd1);
    check("d0_blank_bcd", 32'(bcd_out), 32'd1);
    check("d0_blank_en", 32'(dig_en), 32'd0);
    tick(2);
    check("d0_show_en", 32'(dig_en), 32'b0001);
    check("d0_show_blank", 32'(blank), 32'd0);
    tick(8);
    check("d1_show_en", 32'(dig_en), 32'b0010);
    check("d1_show_bcd", 32'(bcd_out), 32'd2);

    // 3. backpressure: B held while A is pending
    write(16'h1111);
    write(16'h2222);
    wr_valid = 1'b0;
    check("bp_wr_ready", 32'(wr_ready), 32'd0);
    check("bp_bcd_a", 32'(bcd_out), 32'd1);
    wait_fd(n);
    check("bp_fd_gap", 32'(n), 32'd31);
    check("bp_bcd_b", 32'(bcd_out), 32'd2);

    // 4. invalid code in digit 2
    write(16'h9A05);
    wr_valid = 1'b0;
    wait_fd(n);
    check("inv_d0_bcd", 32'(bcd_out), 32'd5);
    tick(18);
    check("inv_d2_cur", 32'(cur_digit), 32'd2);
    check("inv_d2_bcd", 32'(bcd_out), 32'hA);
    check("inv_d2_en", 32'(dig_en), 32'd0);
    check("inv_d2_blank", 32'(blank), 32'd1);
    tick(8);
    check("inv_d3_en", 32'(dig_en), 32'b1000);
    check("inv_d3_bcd", 32'(bcd_out), 32'd9);
    tick(8);
    check("inv_d0_en", 32'(dig_en), 32'b0001);
    check("inv_d0_show_bcd", 32'(bcd_out), 32'd5);

    // 5. en drop during digit 2 SHOW, commit in IDLE, restart
    write(16'h0678);
    wr_valid = 1'b0;
    tick(15);
    check("drop_cur_before", 32'(cur_digit), 32'd2);
    en = 1'b0;
    tick(1);
    check("drop_en", 32'(dig_en), 32'd0);
    check("drop_cur", 32'(cur_digit), 32'd0);
    check("drop_blank", 32'(blank), 32'd1);
    check("drop_pending", 32'(wr_ready), 32'd0);
    tick(1);
    check("idle_commit_ready", 32'(wr_ready), 32'd1);
    en = 1'b1;
    tick(1);
    check("restart_bcd", 32'(bcd_out), 32'd8);
    check("restart_en", 32'(dig_en), 32'd0);
    tick(2);
    check("restart_show_en", 32'(dig_en), 32'b0001);

    // 6. reset while pending is full and digit 3 is lit
    write(16'h5555);
    wr_valid = 1'b0;
    tick(23);
    check("pre_rst_en", 32'(dig_en), 32'b1000);
    check("pre_rst_ready", 32'(wr_ready), 32'd0);
    rst_n = 1'b0;
    tick(1);
    check("mid_rst_en", 32'(dig_en), 32'd0);
    check("mid_rst_blank", 32'(blank), 32'd1);
    check("mid_rst_cur", 32'(cur_digit), 32'd0);
    check("mid_rst_bcd", 32'(bcd_out), 32'd0);
    check("mid_rst_fd", 32'(frame_done), 32'd0);
    check("mid_rst_ready", 32'(wr_ready), 32'd1);
    rst_n = 1'b1;
    tick(1);
    check("post_rst_bcd", 32'(bcd_out), 32'hF);
    wait_fd(n);
    check("post_rst_period", 32'(n), 32'd32);
    check("post_rst_frame_bcd", 32'(bcd_out), 32'hF);
    tick(2);

    chk_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
